// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_pkg
// Description : Shared types and constants for the UART 8N1 transmitter.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_e;

    localparam int   UART_DATA_BITS = 8;
    localparam logic UART_IDLE_LVL  = 1'b1;
    localparam logic UART_START_LVL = 1'b0;

    // 40 MHz system clock at 9600 baud.
    localparam int   UART_BAUD_DIV  = 4167;

endpackage
`default_nettype wire

// File: rtl/uart_tx_fifo.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_fifo
// Description : Synchronous byte FIFO with push/pop/clear and level output.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int DATA_W = UART_DATA_BITS,
    parameter int LVL_W  = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [DATA_W-1:0] din,
    input  logic              pop,
    input  logic              clear,
    output logic [DATA_W-1:0] dout,
    output logic              full,
    output logic              empty,
    output logic [LVL_W-1:0]  level
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [LVL_W-1:0]  r_level;
    logic              r_full;
    logic [LVL_W-1:0]  w_level_nxt;
    logic              w_push;
    logic              w_pop;

    // Clear beats a concurrent push; a concurrent pop still hands out the head.
    assign w_push = push & ~r_full & ~clear;
    assign w_pop  = pop & (r_level != '0);

    always_comb begin
        w_level_nxt = r_level;
        if (clear) begin
            w_level_nxt = '0;
        end else if (w_push && !w_pop) begin
            w_level_nxt = r_level + LVL_W'(1);
        end else if (!w_push && w_pop) begin
            w_level_nxt = r_level - LVL_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
            r_full   <= 1'b0;
        end else begin
            r_level <= w_level_nxt;
            r_full  <= (w_level_nxt == LVL_W'(DEPTH));
            if (clear) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
            end else begin
                if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
                if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= din;
    end

    assign dout  = r_mem[r_rd_ptr];
    assign full  = r_full;
    assign empty = (r_level == '0);
    assign level = r_level;

endmodule
`default_nettype wire

// File: rtl/uart_tx_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_ctrl
// Description : UART 8N1 transmitter with byte FIFO, drives the serial line.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_ctrl
    import uart_pkg::*;
#(
    parameter int BAUD_DIV   = UART_BAUD_DIV,
    parameter int FIFO_DEPTH = 4,
    parameter int LVL_W      = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                      wb_clk_i,
    input  logic                      wb_rst_i,
    input  logic                      tx_start,
    input  logic [UART_DATA_BITS-1:0] tx_data,
    input  logic                      tx_clear_req,
    output logic                      tx_busy,
    output logic                      tx_full,
    output logic                      tx_done,
    output logic [LVL_W-1:0]          tx_level,
    output logic                      ser_tx
);

    localparam int CNT_W = $clog2(BAUD_DIV);
    localparam int IDX_W = $clog2(UART_DATA_BITS);
    localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(BAUD_DIV - 1);
    localparam logic [CNT_W-1:0] c_cnt_done = CNT_W'(BAUD_DIV - 2);
    localparam logic [IDX_W-1:0] c_idx_last = IDX_W'(UART_DATA_BITS - 1);

    uart_state_e               r_state;
    logic [CNT_W-1:0]          r_cnt;
    logic [IDX_W-1:0]          r_idx;
    logic [UART_DATA_BITS-1:0] r_shift;
    logic                      r_ser;
    logic                      r_done;

    logic [UART_DATA_BITS-1:0] w_fifo_dout;
    logic                      w_fifo_empty;
    logic                      w_bit_end;
    logic                      w_pop;
    logic [IDX_W-1:0]          w_idx_nxt;

    assign w_bit_end = (r_cnt == c_cnt_last);
    assign w_idx_nxt = r_idx + IDX_W'(1);
    // Pop either from idle or at the very end of a stop bit, so frames abut.
    assign w_pop     = ~w_fifo_empty &
                       ((r_state == IDLE) | ((r_state == STOP) & w_bit_end));

    uart_tx_fifo #(
        .DEPTH  (FIFO_DEPTH),
        .DATA_W (UART_DATA_BITS),
        .LVL_W  (LVL_W)
    ) u_fifo (
        .clk    (wb_clk_i),
        .rst    (wb_rst_i),
        .push   (tx_start),
        .din    (tx_data),
        .pop    (w_pop),
        .clear  (tx_clear_req),
        .dout   (w_fifo_dout),
        .full   (tx_full),
        .empty  (w_fifo_empty),
        .level  (tx_level)
    );

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_shift <= '0;
            r_ser   <= UART_IDLE_LVL;
            r_done  <= 1'b0;
        end else begin
            // Registered one cycle early so the pulse lands on the last stop cycle.
            r_done <= (r_state == STOP) && (r_cnt == c_cnt_done);
            case (r_state)
                IDLE: begin
                    r_ser <= UART_IDLE_LVL;
                    r_cnt <= '0;
                    if (w_pop) begin
                        r_shift <= w_fifo_dout;
                        r_ser   <= UART_START_LVL;
                        r_state <= START;
                    end
                end
                START: begin
                    if (w_bit_end) begin
                        r_cnt   <= '0;
                        r_idx   <= '0;
                        r_ser   <= r_shift[0];
                        r_state <= DATA;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                DATA: begin
                    if (w_bit_end) begin
                        r_cnt <= '0;
                        if (r_idx == c_idx_last) begin
                            r_ser   <= UART_IDLE_LVL;
                            r_state <= STOP;
                        end else begin
                            r_idx <= w_idx_nxt;
                            r_ser <= r_shift[w_idx_nxt];
                        end
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                STOP: begin
                    if (w_bit_end) begin
                        r_cnt <= '0;
                        if (w_pop) begin
                            r_shift <= w_fifo_dout;
                            r_ser   <= UART_START_LVL;
                            r_state <= START;
                        end else begin
                            r_state <= IDLE;
                        end
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    r_ser   <= UART_IDLE_LVL;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign tx_busy = (tx_level != '0) || (r_state != IDLE);
    assign tx_done = r_done;
    assign ser_tx  = r_ser;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_tx_ctrl
// Description : Scoreboard bench for uart_tx_ctrl with a serial-line decoder.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Fast instance for directed tests
    logic       rst_a, start_a, clr_a;
    logic [7:0] data_a;
    logic       busy_a, full_a, done_a, ser_a;
    logic [2:0] level_a;

    // Real-rate instance for the loopback check
    logic       rst_b, start_b, clr_b;
    logic [7:0] data_b;
    logic       busy_b, full_b, done_b, ser_b;
    logic [2:0] level_b;

    uart_tx_ctrl #(.BAUD_DIV(4), .FIFO_DEPTH(4)) u_dut_a (
        .wb_clk_i(clk), .wb_rst_i(rst_a), .tx_start(start_a), .tx_data(data_a),
        .tx_clear_req(clr_a), .tx_busy(busy_a), .tx_full(full_a), .tx_done(done_a),
        .tx_level(level_a), .ser_tx(ser_a)
    );

    uart_tx_ctrl #(.BAUD_DIV(4167), .FIFO_DEPTH(4)) u_dut_b (
        .wb_clk_i(clk), .wb_rst_i(rst_b), .tx_start(start_b), .tx_data(data_b),
        .tx_clear_req(clr_b), .tx_busy(busy_b), .tx_full(full_b), .tx_done(done_b),
        .tx_level(level_b), .ser_tx(ser_b)
    );

    logic [7:0] exp_a[$];
    logic [7:0] exp_b[$];
    int         done_q[$];
    int         frames_b = 0;
    int         n_vec = 0;
    int         n_err = 0;

    always @(negedge clk) if (done_a === 1'b1) done_q.push_back(cyc);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic line_of(input bit sel);
        return sel ? ser_b : ser_a;
    endfunction

    function automatic logic rst_of(input bit sel);
        return sel ? rst_b : rst_a;
    endfunction

    // Offsets count negedges from the one that first saw the start bit.
    task automatic rx_frame(input bit sel, input int bd, output logic [9:0] bits,
                            output logic dn, output bit aborted);
        int off;
        int target;
        off = 0;
        bits = '1;
        dn = 1'b0;
        aborted = 1'b0;
        for (int k = 0; k < 11; k++) begin
            target = (k < 10) ? (k * bd + bd / 2) : (10 * bd - 1);
            while (off < target) begin
                @(negedge clk);
                off++;
                if (rst_of(sel) === 1'b1) begin
                    aborted = 1'b1;
                    return;
                end
            end
            if (k < 10) bits[k] = line_of(sel);
            else        dn = sel ? done_b : done_a;
        end
    endtask

    task automatic monitor(input bit sel, input int bd);
        logic [9:0] bits;
        logic       dn;
        bit         ab;
        logic [7:0] e;
        int         qsz;
        forever begin
            @(negedge clk);
            if (line_of(sel) === 1'b0 && rst_of(sel) === 1'b0) begin
                rx_frame(sel, bd, bits, dn, ab);
                if (!ab) begin
                    qsz = sel ? exp_b.size() : exp_a.size();
                    if (qsz == 0) begin
                        n_vec++;
                        n_err++;
                        $display("FAIL unexpected_frame: got byte 0x%02h, required no frame", bits[8:1]);
                    end else begin
                        if (sel) e = exp_b.pop_front();
                        else     e = exp_a.pop_front();
                        chk("start_bit", {31'd0, bits[0]}, 32'd0);
                        chk("rx_byte", {24'd0, bits[8:1]}, {24'd0, e});
                        chk("stop_bit", {31'd0, bits[9]}, 32'd1);
                        chk("done_at_stop_end", {31'd0, dn}, 32'd1);
                        if (sel) frames_b++;
                    end
                end
            end
        end
    endtask

    initial monitor(1'b0, 4);
    initial monitor(1'b1, 4167);

    task automatic offer(input logic [7:0] b, input bit acc);
        start_a = 1'b1;
        data_a  = b;
        if (acc) exp_a.push_back(b);
        @(posedge clk);
        #1;
        start_a = 1'b0;
    endtask

    task automatic wait_idle(input int limit);
        int i;
        i = 0;
        while (busy_a !== 1'b0 && i < limit) begin
            @(negedge clk);
            i++;
        end
        if (busy_a !== 1'b0) begin
            n_vec++;
            n_err++;
            $display("FAIL idle_timeout: busy=%b after %0d cycles, required 0", busy_a, limit);
        end
    endtask

    task automatic wait_done(input int limit);
        int i;
        i = 0;
        while (done_a !== 1'b1 && i < limit) begin
            @(negedge clk);
            i++;
        end
        if (done_a !== 1'b1) begin
            n_vec++;
            n_err++;
            $display("FAIL done_timeout: done=%b after %0d cycles, required 1", done_a, limit);
        end
    endtask

    initial begin
        rst_b = 1'b1; start_b = 1'b0; clr_b = 1'b0; data_b = '0;
        repeat (3) @(posedge clk);
        #1 rst_b = 1'b0;
        start_b = 1'b1; data_b = 8'h41; exp_b.push_back(8'h41);
        @(posedge clk); #1;
        data_b = 8'h42; exp_b.push_back(8'h42);
        @(posedge clk); #1;
        start_b = 1'b0;
    end

    initial begin
        int t;
        rst_a = 1'b1; start_a = 1'b0; clr_a = 1'b0; data_a = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_ser", {31'd0, ser_a}, 32'd1);
        chk("rst_busy", {31'd0, busy_a}, 32'd0);
        chk("rst_full", {31'd0, full_a}, 32'd0);
        chk("rst_done", {31'd0, done_a}, 32'd0);
        chk("rst_level", {29'd0, level_a}, 32'd0);
        rst_a = 1'b0;

        // Single byte 0xA5
        @(negedge clk);
        done_q.delete();
        offer(8'hA5, 1'b1);
        t = cyc;
        @(negedge clk);
        chk("accept_ser_still_high", {31'd0, ser_a}, 32'd1);
        chk("accept_level", {29'd0, level_a}, 32'd1);
        chk("accept_busy", {31'd0, busy_a}, 32'd1);
        @(negedge clk);
        chk("start_latency_ser", {31'd0, ser_a}, 32'd0);
        chk("pop_level", {29'd0, level_a}, 32'd0);
        wait_idle(100);
        chk("busy_fall_cycle", cyc, t + 41);
        chk("single_done_count", done_q.size(), 32'd1);
        chk("single_done_cycle", (done_q.size() > 0) ? done_q[0] : -1, t + 40);

        // Back-to-back 00, FF, 55
        @(negedge clk);
        done_q.delete();
        offer(8'h00, 1'b1);
        t = cyc;
        offer(8'hFF, 1'b1);
        offer(8'h55, 1'b1);
        @(negedge clk);
        chk("b2b_level_peak", {29'd0, level_a}, 32'd2);
        wait_idle(200);
        chk("b2b_done_count", done_q.size(), 32'd3);
        chk("b2b_done0", (done_q.size() > 0) ? done_q[0] : -1, t + 40);
        chk("b2b_done1", (done_q.size() > 1) ? done_q[1] : -1, t + 80);
        chk("b2b_done2", (done_q.size() > 2) ? done_q[2] : -1, t + 120);

        // Overflow: 6 offers, one in flight, four queued, one dropped
        @(negedge clk);
        offer(8'h11, 1'b1);
        offer(8'h22, 1'b1);
        offer(8'h33, 1'b1);
        offer(8'h44, 1'b1);
        offer(8'h5A, 1'b1);
        offer(8'hE7, 1'b0);
        @(negedge clk);
        chk("ovf_full", {31'd0, full_a}, 32'd1);
        chk("ovf_level", {29'd0, level_a}, 32'd4);
        wait_idle(400);

        // Clear during DATA with three queued; offered byte on the clear edge is dropped
        @(negedge clk);
        offer(8'h96, 1'b1);
        offer(8'h01, 1'b0);
        offer(8'h02, 1'b0);
        offer(8'h03, 1'b0);
        @(negedge clk);
        chk("clr_pre_level", {29'd0, level_a}, 32'd3);
        repeat (5) @(posedge clk);
        #1;
        clr_a = 1'b1; start_a = 1'b1; data_a = 8'hEE;
        @(posedge clk);
        #1;
        clr_a = 1'b0; start_a = 1'b0;
        @(negedge clk);
        chk("clr_level", {29'd0, level_a}, 32'd0);
        chk("clr_full", {31'd0, full_a}, 32'd0);
        chk("clr_busy_inflight", {31'd0, busy_a}, 32'd1);
        wait_idle(100);
        @(negedge clk);
        chk("clr_idle_ser", {31'd0, ser_a}, 32'd1);

        // Clear on the same edge as a pop: popped byte still goes out
        offer(8'h81, 1'b1);
        offer(8'h42, 1'b1);
        offer(8'h24, 1'b0);
        wait_done(100);
        clr_a = 1'b1;
        @(posedge clk);
        #1;
        clr_a = 1'b0;
        @(negedge clk);
        chk("clrpop_level", {29'd0, level_a}, 32'd0);
        chk("clrpop_ser_start", {31'd0, ser_a}, 32'd0);
        wait_idle(100);

        // Reset during bit 3 of 0x3C with 0x99 queued
        @(negedge clk);
        offer(8'h3C, 1'b0);
        offer(8'h99, 1'b0);
        repeat (17) @(posedge clk);
        #1 rst_a = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("midrst_ser", {31'd0, ser_a}, 32'd1);
        chk("midrst_busy", {31'd0, busy_a}, 32'd0);
        chk("midrst_level", {29'd0, level_a}, 32'd0);
        rst_a = 1'b0;
        @(negedge clk);
        offer(8'hC3, 1'b1);
        wait_idle(100);

        while (frames_b < 2 && cyc < 95000) @(negedge clk);
        chk("loopback_frames", frames_b, 32'd2);
        chk("exp_a_drained", exp_a.size(), 32'd0);
        chk("exp_b_drained", exp_b.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/uart_tx_ctrl.md
Name: uart_tx_ctrl

Overview:
- UART 8N1 transmitter that drives the serial line into the Caravel UART receive pin, mprj_io[5].
- Bytes are offered with a start/busy handshake and buffered in a small FIFO.
- Each byte is serialised LSB-first at a fixed divisor-derived baud rate.
- It provides the host-to-chip direction that complements the existing chip-to-host UART monitor, so firmware receive and interrupt paths can be exercised.

Parameters:
- BAUD_DIV, 4167: clock cycles per UART bit. 40 MHz / 9600 baud. Legal range is 2 or more.
- FIFO_DEPTH, 4: number of byte-buffer entries. Must be a power of two and at least 2.
- LVL_W, $clog2(FIFO_DEPTH)+1: width of the level output. Derived; do not override.

Ports:
- wb_clk_i  in  1  system clock.
- wb_rst_i  in  1  reset. Synchronous, active-high.
- tx_start  in  1  byte-valid request. The byte is accepted on any rising edge where tx_start=1, tx_full=0 and tx_clear_req=0.
- tx_data  in  8  byte to send. Sampled on the accepting edge.
- tx_clear_req  in  1  flushes all queued, not-yet-started bytes.
- tx_busy  out  1  high while the FIFO is non-empty or a frame is in flight.
- tx_full  out  1  high when the FIFO holds FIFO_DEPTH entries.
- tx_done  out  1  one-cycle pulse on the last cycle of each stop bit.
- tx_level  out  LVL_W  current FIFO occupancy, 0..FIFO_DEPTH.
- ser_tx  out  1  serial line. Idles high.

Behaviour:
- Reset values, taking effect on the first edge with wb_rst_i=1:
  - ser_tx=1, tx_busy=0, tx_full=0, tx_done=0, tx_level=0.
  - FSM in IDLE; baud counter and bit index cleared.
  - Reset asserted mid-frame aborts the frame: ser_tx returns high on that edge and all queued bytes are lost.
- FSM states and transitions:
  - IDLE: ser_tx=1. If the FIFO is non-empty, pop the head into the shift register, go to START, and drive ser_tx=0 registered.
  - START: lasts BAUD_DIV cycles, then go to DATA with bit index 0.
  - DATA: ser_tx = shift[idx] for BAUD_DIV cycles per bit. Bits are sent idx 0..7, LSB first. After idx 7 go to STOP.
  - STOP: ser_tx=1 for BAUD_DIV cycles. tx_done pulses on the final cycle. Then:
    - if the FIFO is non-empty, pop and go directly to START, with no idle gap between frames;
    - otherwise go to IDLE.
- Timing and latency:
  - If a byte is accepted at edge N into an empty FIFO while the FSM is in IDLE, ser_tx falls at edge N+1.
  - A frame lasts exactly 10*BAUD_DIV cycles.
  - The baud counter counts 0..BAUD_DIV-1 and wraps. A bit boundary is where the counter equals BAUD_DIV-1.
- FIFO rules:
  - Push and pop on the same edge leave tx_level unchanged.
  - A push when full is ignored: no state change, no overwrite.
  - Pointers wrap modulo FIFO_DEPTH.
- tx_clear_req:
  - Empties the FIFO on that edge.
  - A frame already in flight completes normally.
  - tx_clear_req together with tx_start: clear wins and the offered byte is dropped.
  - tx_clear_req on the same edge as a pop: the popped byte is sent, and the remaining entries are cleared.
- Output timing:
  - tx_busy is combinational from the registered state: (tx_level != 0) || (state != IDLE).
  - tx_full and tx_level are registered-derived, with no combinational path from tx_start.
- All outputs are glitch-free registers except tx_busy.

Decomposition:
- Package uart_pkg contains:
  - the FSM state enum: IDLE, START, DATA, STOP;
  - constants UART_DATA_BITS=8, UART_IDLE_LVL=1'b1, UART_START_LVL=1'b0;
  - a shared BAUD_DIV default.
- One sub-module, uart_tx_fifo: a synchronous FIFO with push/pop/clear, full/empty flags and a level output. The FSM, baud counter and shifter stay in uart_tx_ctrl.

Test Plan:
- Single byte, BAUD_DIV=4, tx_data=8'hA5:
  - ser_tx falls 1 cycle after acceptance;
  - line sequence, one bit per 4 cycles: 0, 1,0,1,0,0,1,0,1, 1;
  - tx_done pulses at cycle 40 of the frame;
  - tx_busy deasserts the cycle after.
- Back-to-back, bytes 8'h00, 8'hFF, 8'h55 offered on consecutive cycles:
  - tx_level peaks at 2;
  - 30*BAUD_DIV cycles of contiguous frames with no idle gap;
  - three tx_done pulses spaced 40 cycles apart.
- Overflow, FIFO_DEPTH=4, 6 bytes offered while a frame is in flight:
  - exactly 4 bytes are queued and tx_full=1;
  - the extra 1 is ignored;
  - bytes are transmitted in order, and the ignored byte never appears on ser_tx.
- Clear mid-frame, clear asserted during the DATA state with 3 bytes queued:
  - the current frame completes intact;
  - tx_level=0 the next cycle;
  - ser_tx idles high after STOP;
  - tx_start together with clear drops that byte.
- Reset mid-frame, wb_rst_i pulsed during bit 3 of 8'h3C:
  - ser_tx=1, tx_busy=0, tx_level=0 on the reset edge;
  - a new byte 8'hC3 afterwards transmits correctly.
- Loopback with the existing UART monitor model at BAUD_DIV=4167, sending "AB":
  - the monitor decodes 8'h41, 8'h42.
